// File: rtl/dino_game_state_pkg.sv
// Shared state encoding, default playfield geometry and BCD helpers for the
// dino game blocks (generator, state controller, renderer).
package dino_game_state_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HIT  = 2'd2,
        ST_OVER = 2'd3
    } state_t;

    localparam int DEF_DINO_X    = 80;
    localparam int DEF_DINO_W    = 20;
    localparam int DEF_DINO_H    = 22;
    localparam int DEF_OBST_W    = 15;
    localparam int DEF_OBST_H    = 30;
    localparam int DEF_GROUND_Y  = 400;
    localparam int DEF_SCORE_DIV = 6;
    localparam int DEF_HIT_TICKS = 30;

    localparam logic [15:0] BCD_MAX = 16'h9999;

    // Four-digit BCD increment with per-digit carry; sticks at 9999.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        if (v == BCD_MAX) begin
            return v;
        end
        for (int unsigned i = 0; i < 4; i++) begin
            if (c) begin
                if (r[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/dino_game_state_bcd_counter4.sv
// Four-digit BCD counter: synchronous clear, increment enable, saturates at 9999.
module bcd_counter4
    import dino_game_state_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_clr,
    input  logic        i_inc,
    output logic [15:0] o_bcd
);

    logic [15:0] r_bcd;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clr) begin
            r_bcd <= '0;
        end else if (i_inc) begin
            r_bcd <= bcd_inc(r_bcd);
        end
    end

    assign o_bcd = r_bcd;

endmodule

// File: rtl/dino_game_state.sv
// Game-state controller: collision detection, IDLE/RUN/HIT/OVER sequencing,
// BCD score / high score, and the gated tick + reset back to the obstacle generator.
module dino_game_state
    import dino_game_state_pkg::*;
#(
    parameter int DINO_X    = DEF_DINO_X,
    parameter int DINO_W    = DEF_DINO_W,
    parameter int DINO_H    = DEF_DINO_H,
    parameter int OBST_W    = DEF_OBST_W,
    parameter int OBST_H    = DEF_OBST_H,
    parameter int GROUND_Y  = DEF_GROUND_Y,
    parameter int SCORE_DIV = DEF_SCORE_DIV,
    parameter int HIT_TICKS = DEF_HIT_TICKS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        game_tick,
    input  logic        start_btn,
    input  logic [9:0]  dino_y,
    input  logic [9:0]  obstacle_x1,
    input  logic [9:0]  obstacle_x2,
    output logic        run_tick,
    output logic        obs_rst,
    output logic        game_over,
    output logic        hit_flash,
    output logic [15:0] score_bcd,
    output logic [15:0] hi_score_bcd
);

    localparam int DIV_W = $clog2(SCORE_DIV + 1);
    localparam int HIT_W = ($clog2(HIT_TICKS + 1) < 3) ? 3 : $clog2(HIT_TICKS + 1);

    localparam logic [10:0] X_LO  = 11'(DINO_X);
    localparam logic [10:0] X_HI  = 11'(DINO_X + DINO_W);
    localparam logic [10:0] OW    = 11'(OBST_W);
    localparam logic [10:0] DH    = 11'(DINO_H);
    localparam logic [10:0] Y_TOP = 11'(GROUND_Y - OBST_H);

    state_t             r_state, w_state_next;
    logic               r_start_q, r_start_prev;
    logic               w_start_rise;
    logic [DIV_W-1:0]   r_div, w_div_next;
    logic [HIT_W-1:0]   r_hit_cnt, w_hit_cnt_next;
    logic               w_vert, w_hit1, w_hit2, w_collide;
    logic               w_score_clr, w_score_inc;
    logic               r_obs_rst, r_game_over, r_hit_flash;
    logic [15:0]        r_hi_score, w_score;

    assign w_start_rise = r_start_q && !r_start_prev;

    // 11-bit sums so obstacles near x=1023 cannot wrap into a false overlap.
    assign w_vert    = ({1'b0, dino_y} + DH) > Y_TOP;
    assign w_hit1    = ({1'b0, obstacle_x1} < X_HI) && (({1'b0, obstacle_x1} + OW) > X_LO);
    assign w_hit2    = ({1'b0, obstacle_x2} < X_HI) && (({1'b0, obstacle_x2} + OW) > X_LO);
    assign w_collide = w_vert && (w_hit1 || w_hit2);

    always_comb begin
        w_state_next   = r_state;
        w_div_next     = r_div;
        w_hit_cnt_next = r_hit_cnt;
        w_score_inc    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_div_next = '0;
                if (w_start_rise) w_state_next = ST_RUN;
            end
            ST_RUN: begin
                if (game_tick) begin
                    if (w_collide) begin
                        w_state_next   = ST_HIT;
                        w_hit_cnt_next = '0;
                    end else if (r_div == DIV_W'(SCORE_DIV - 1)) begin
                        w_div_next  = '0;
                        w_score_inc = 1'b1;
                    end else begin
                        w_div_next = r_div + 1'b1;
                    end
                end
            end
            ST_HIT: begin
                if (game_tick) begin
                    if (r_hit_cnt == HIT_W'(HIT_TICKS - 1)) begin
                        w_state_next = ST_OVER;
                    end else begin
                        w_hit_cnt_next = r_hit_cnt + 1'b1;
                    end
                end
            end
            ST_OVER: begin
                if (w_start_rise) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Clearing on entry as well keeps the score at 0 for the whole IDLE stay.
    assign w_score_clr = (r_state == ST_IDLE) || (w_state_next == ST_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_start_q    <= 1'b0;
            r_start_prev <= 1'b0;
            r_div        <= '0;
            r_hit_cnt    <= '0;
            r_obs_rst    <= 1'b1;
            r_game_over  <= 1'b0;
            r_hit_flash  <= 1'b0;
            r_hi_score   <= '0;
        end else begin
            r_state      <= w_state_next;
            r_start_q    <= start_btn;
            r_start_prev <= r_start_q;
            r_div        <= w_div_next;
            r_hit_cnt    <= w_hit_cnt_next;
            r_obs_rst    <= (w_state_next == ST_IDLE);
            r_game_over  <= (w_state_next == ST_OVER);
            r_hit_flash  <= (w_state_next == ST_HIT) && w_hit_cnt_next[2];
            if ((r_state == ST_HIT) && (w_state_next == ST_OVER) && (w_score > r_hi_score)) begin
                r_hi_score <= w_score;
            end
        end
    end

    bcd_counter4 u_score (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_clr   (w_score_clr),
        .i_inc   (w_score_inc),
        .o_bcd   (w_score)
    );

    assign run_tick     = game_tick && (r_state == ST_RUN);
    assign obs_rst      = r_obs_rst;
    assign game_over    = r_game_over;
    assign hit_flash    = r_hit_flash;
    assign score_bcd    = w_score;
    assign hi_score_bcd = r_hi_score;

endmodule

// File: tb/tb_dino_game_state.sv
// Directed bench for dino_game_state: a default-parameter instance for game flow
// and collision boundaries, plus a SCORE_DIV=1 instance for BCD carry/saturation.
module tb_dino_game_state;

    logic        clk;
    logic        rst_n, game_tick, start_btn;
    logic [9:0]  dino_y, obstacle_x1, obstacle_x2;
    logic        run_tick, obs_rst, game_over, hit_flash;
    logic [15:0] score_bcd, hi_score_bcd;

    logic        s_rst_n, s_tick, s_start;
    logic [9:0]  s_dino_y, s_x1, s_x2;
    logic        s_run_tick, s_obs_rst, s_game_over, s_hit_flash;
    logic [15:0] s_score, s_hi;

    int n_checks = 0;
    int n_errors = 0;

    dino_game_state u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .game_tick    (game_tick),
        .start_btn    (start_btn),
        .dino_y       (dino_y),
        .obstacle_x1  (obstacle_x1),
        .obstacle_x2  (obstacle_x2),
        .run_tick     (run_tick),
        .obs_rst      (obs_rst),
        .game_over    (game_over),
        .hit_flash    (hit_flash),
        .score_bcd    (score_bcd),
        .hi_score_bcd (hi_score_bcd)
    );

    dino_game_state #(.SCORE_DIV(1)) u_sat (
        .clk          (clk),
        .rst_n        (s_rst_n),
        .game_tick    (s_tick),
        .start_btn    (s_start),
        .dino_y       (s_dino_y),
        .obstacle_x1  (s_x1),
        .obstacle_x2  (s_x2),
        .run_tick     (s_run_tick),
        .obs_rst      (s_obs_rst),
        .game_over    (s_game_over),
        .hit_flash    (s_hit_flash),
        .score_bcd    (s_score),
        .hi_score_bcd (s_hi)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        game_tick = 1'b1;
        @(negedge clk);
        game_tick = 1'b0;
    endtask

    // Raises game_tick briefly between edges to observe the RUN gate without consuming a tick.
    task automatic probe_run(input string tag, input logic exp);
        game_tick = 1'b1;
        #1;
        check(tag, {15'd0, run_tick}, {15'd0, exp});
        game_tick = 1'b0;
    endtask

    task automatic press();
        start_btn = 1'b1;
        @(negedge clk);
        start_btn = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; game_tick = 1'b0; start_btn = 1'b0;
        dino_y = 10'd300; obstacle_x1 = 10'd540; obstacle_x2 = 10'd750;
        s_rst_n = 1'b0; s_tick = 1'b0; s_start = 1'b0;
        s_dino_y = 10'd300; s_x1 = 10'd540; s_x2 = 10'd750;
        repeat (3) @(negedge clk);

        check("rst_obs_rst",   {15'd0, obs_rst},   16'd1);
        check("rst_game_over", {15'd0, game_over}, 16'd0);
        check("rst_hit_flash", {15'd0, hit_flash}, 16'd0);
        check("rst_score",     score_bcd,          16'h0000);
        check("rst_hi",        hi_score_bcd,       16'h0000);
        rst_n = 1'b1;
        @(negedge clk);
        probe_run("idle_run_tick", 1'b0);

        // Start: obs_rst still high one cycle after the edge, low after two.
        press();
        check("obs_rst_1cyc", {15'd0, obs_rst}, 16'd1);
        @(negedge clk);
        check("obs_rst_2cyc", {15'd0, obs_rst}, 16'd0);

        game_tick = 1'b1;
        #1 check("run_tick_hi", {15'd0, run_tick}, 16'd1);
        @(negedge clk);
        game_tick = 1'b0;
        #1 check("run_tick_lo", {15'd0, run_tick}, 16'd0);
        repeat (59) tick();
        check("score_60", score_bcd, 16'h0010);
        check("no_over_60", {15'd0, game_over}, 16'd0);

        // Horizontal/vertical boundaries that must not collide (divider 1..3).
        dino_y = 10'd378; obstacle_x1 = 10'd100; tick();
        probe_run("x100_nohit", 1'b1);
        obstacle_x1 = 10'd65; tick();
        probe_run("x65_nohit", 1'b1);
        dino_y = 10'd348; obstacle_x1 = 10'd90; tick();
        probe_run("y348_nohit", 1'b1);
        dino_y = 10'd300; obstacle_x1 = 10'd540;
        tick(); tick();
        check("score_div5", score_bcd, 16'h0010);

        // Collision on the tick that would have incremented the score.
        dino_y = 10'd378; obstacle_x1 = 10'd99; tick();
        probe_run("x99_hit", 1'b0);
        check("collide_wins", score_bcd, 16'h0010);

        press();
        @(negedge clk);
        check("hit_ignores_start", {15'd0, obs_rst | game_over}, 16'd0);
        probe_run("hit_still", 1'b0);

        repeat (3) tick();
        check("flash_t3", {15'd0, hit_flash}, 16'd0);
        tick();
        check("flash_t4", {15'd0, hit_flash}, 16'd1);
        repeat (4) tick();
        check("flash_t8", {15'd0, hit_flash}, 16'd0);
        repeat (21) tick();
        check("over_t29", {15'd0, game_over}, 16'd0);
        tick();
        check("over_t30", {15'd0, game_over}, 16'd1);
        check("over_flash", {15'd0, hit_flash}, 16'd0);
        check("hi_g1", hi_score_bcd, 16'h0010);
        check("score_g1", score_bcd, 16'h0010);

        // OVER -> IDLE -> RUN, second lower-scoring game.
        dino_y = 10'd300; obstacle_x1 = 10'd540;
        press();
        check("over_hold", {15'd0, game_over}, 16'd1);
        @(negedge clk);
        check("idle_obs_rst", {15'd0, obs_rst}, 16'd1);
        check("idle_go", {15'd0, game_over}, 16'd0);
        check("idle_score", score_bcd, 16'h0000);
        press();
        @(negedge clk);
        probe_run("g2_run", 1'b1);
        repeat (12) tick();
        check("score_g2", score_bcd, 16'h0002);
        dino_y = 10'd378; obstacle_x1 = 10'd66; tick();
        probe_run("x66_hit", 1'b0);
        repeat (30) tick();
        check("over_g2", {15'd0, game_over}, 16'd1);
        check("hi_kept", hi_score_bcd, 16'h0010);
        check("score_g2_over", score_bcd, 16'h0002);

        // Third game: vertical boundary via obstacle 2, then reset inside HIT.
        dino_y = 10'd300; obstacle_x1 = 10'd540;
        press(); @(negedge clk);
        press(); @(negedge clk);
        probe_run("g3_run", 1'b1);
        dino_y = 10'd349; obstacle_x2 = 10'd90; tick();
        probe_run("y349_x2_hit", 1'b0);
        repeat (4) tick();
        check("flash_pre_rst", {15'd0, hit_flash}, 16'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_rst_obs_rst", {15'd0, obs_rst},   16'd1);
        check("mid_rst_go",      {15'd0, game_over}, 16'd0);
        check("mid_rst_flash",   {15'd0, hit_flash}, 16'd0);
        check("mid_rst_score",   score_bcd,          16'h0000);
        check("mid_rst_hi",      hi_score_bcd,       16'h0000);
        probe_run("mid_rst_run", 1'b0);

        // Saturation on the one-tick-per-point instance.
        s_rst_n = 1'b1;
        @(negedge clk);
        s_start = 1'b1; @(negedge clk); s_start = 1'b0; @(negedge clk);
        s_tick = 1'b1;
        repeat (99) @(negedge clk);
        s_tick = 1'b0;
        check("sat_0099", s_score, 16'h0099);
        s_tick = 1'b1;
        @(negedge clk);
        s_tick = 1'b0;
        check("sat_0100", s_score, 16'h0100);
        s_tick = 1'b1;
        repeat (9898) @(negedge clk);
        s_tick = 1'b0;
        check("sat_9998", s_score, 16'h9998);
        s_tick = 1'b1;
        repeat (2) @(negedge clk);
        s_tick = 1'b0;
        check("sat_9999", s_score, 16'h9999);
        s_tick = 1'b1;
        repeat (5) @(negedge clk);
        s_tick = 1'b0;
        check("sat_hold", s_score, 16'h9999);
        check("sat_no_over", {15'd0, s_game_over}, 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
